// File: rtl/fetch_target_queue_pkg.sv
// Shared frontend types for the fetch target queue: block payloads, queue index/pointer
// types and wrap-aware pointer helpers.
package fetch_target_queue_pkg;

    localparam int XLEN      = 32;
    localparam int FTQ_DEPTH = 8;
    localparam int FTQ_IDX_W = $clog2(FTQ_DEPTH);
    localparam int FTQ_PTR_W = FTQ_IDX_W + 1;

    typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;

    typedef struct packed {
        logic    wrap;
        ftqIdx_t idx;
    } ftqPtr_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JUMP = 2'd2,
        BR_RET  = 2'd3
    } BranchType;

    typedef struct packed {
        logic [XLEN-1:0] startAddr;
        logic [XLEN-1:0] endAddr;
        logic [XLEN-1:0] nextAddr;
        logic            taken;
        logic [XLEN-1:0] targetAddr;
        BranchType       branch_type;
    } BPInfo_t;

    typedef struct packed {
        logic [XLEN-1:0] startAddr;
        logic [XLEN-1:0] fallthruAddr;
        logic [XLEN-1:0] targetAddr;
        logic            taken;
        BranchType       branch_type;
    } BPupdateInfo_t;

    // {wrap,idx} counts modulo 2*DEPTH, so a plain increment toggles wrap on idx overflow.
    function automatic ftqPtr_t ftqPtr_inc(input ftqPtr_t p);
        logic [FTQ_PTR_W-1:0] v;
        v = p;
        v = v + FTQ_PTR_W'(1);
        return ftqPtr_t'(v);
    endfunction

    // True when a is strictly older than b (a was allocated first).
    function automatic logic ftqPtr_cmp(input ftqPtr_t a, input ftqPtr_t b);
        if (a.wrap == b.wrap) return a.idx < b.idx;
        return a.idx >= b.idx;
    endfunction

endpackage

// File: rtl/fetch_target_queue_ptr.sv
// Wrap-aware queue pointer register: synchronous reset, load (redirect) over increment.
module ftq_ptr
    import fetch_target_queue_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    inc,
    input  logic    load,
    input  ftqPtr_t load_val,
    output ftqPtr_t ptr
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)       ptr <= '0;
        else if (load) ptr <= load_val;
        else if (inc)  ptr <= ftqPtr_inc(ptr);
    end

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: buffers predicted fetch blocks from the BPU, issues them in order to
// the IFU, holds them until commit, trains the BPU on commit and truncates on squash.
module fetch_target_queue
    import fetch_target_queue_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_pred_vld,
    output logic            o_ftq_rdy,
    input  BPInfo_t         i_pred_ftqInfo,
    output logic            o_fetch_vld,
    input  logic            i_fetch_rdy,
    output ftqIdx_t         o_fetch_ftqIdx,
    output BPInfo_t         o_fetch_info,
    input  logic            i_squash_vld,
    input  ftqIdx_t         i_squash_ftqIdx,
    input  logic            i_commit_vld,
    input  logic            i_commit_taken,
    input  logic [XLEN-1:0] i_commit_targetAddr,
    input  BranchType       i_commit_branch_type,
    output logic            o_commit_rdy,
    output logic            o_bpu_commit_vld,
    input  logic            i_bpu_update_finished,
    output BPupdateInfo_t   o_BPupdateInfo
);

    ftqPtr_t enq_ptr, fetch_ptr, commit_ptr;
    ftqPtr_t squash_base, squash_ptr;
    logic    full, enq_fire, fetch_fire, pop;
    BPInfo_t mem [FTQ_DEPTH];
    BPInfo_t head;

    assign full             = (enq_ptr.idx == commit_ptr.idx) && (enq_ptr.wrap != commit_ptr.wrap);
    assign o_ftq_rdy        = !rst && !full && !i_squash_vld;
    assign o_fetch_vld      = !rst && (fetch_ptr != enq_ptr) && !i_squash_vld;
    assign o_commit_rdy     = !rst && (commit_ptr != fetch_ptr);
    assign o_bpu_commit_vld = i_commit_vld && o_commit_rdy;

    assign enq_fire   = i_pred_vld && o_ftq_rdy;
    assign fetch_fire = o_fetch_vld && i_fetch_rdy;
    assign pop        = o_bpu_commit_vld && i_bpu_update_finished;

    // The squashing block lies in [commit, fetch), so its wrap bit follows from commit_ptr.
    always_comb begin
        squash_base.idx  = i_squash_ftqIdx;
        squash_base.wrap = (i_squash_ftqIdx >= commit_ptr.idx) ? commit_ptr.wrap : !commit_ptr.wrap;
        squash_ptr       = ftqPtr_inc(squash_base);
    end

    ftq_ptr u_enq_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (enq_fire),
        .load     (i_squash_vld),
        .load_val (squash_ptr),
        .ptr      (enq_ptr)
    );

    ftq_ptr u_fetch_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (fetch_fire),
        .load     (i_squash_vld),
        .load_val (squash_ptr),
        .ptr      (fetch_ptr)
    );

    ftq_ptr u_commit_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (pop),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (commit_ptr)
    );

    // NOTE: payload storage is deliberately not reset; occupancy comes only from the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[enq_ptr.idx] <= i_pred_ftqInfo;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        head           = mem[commit_ptr.idx];
        o_fetch_ftqIdx = '0;
        o_fetch_info   = '0;
        o_BPupdateInfo = '0;
        if (o_fetch_vld) begin
            o_fetch_ftqIdx = fetch_ptr.idx;
            o_fetch_info   = mem[fetch_ptr.idx];
        end
        if (o_commit_rdy) begin
            o_BPupdateInfo.startAddr    = head.startAddr;
            o_BPupdateInfo.fallthruAddr = head.endAddr;
            o_BPupdateInfo.targetAddr   = i_commit_targetAddr;
            o_BPupdateInfo.taken        = i_commit_taken;
            o_BPupdateInfo.branch_type  = i_commit_branch_type;
        end
    end

    a_commit_only_issued_head: assert property (@(posedge clk) disable iff (rst)
        i_commit_vld |-> o_commit_rdy);

    a_squash_in_issued_range: assert property (@(posedge clk) disable iff (rst)
        i_squash_vld |-> ftqPtr_cmp(squash_base, fetch_ptr));

endmodule

// File: tb/tb_fetch_target_queue.sv
// Self-checking bench for fetch_target_queue: directed table, hand sequences for squash/commit
// corners, then randomized traffic against a queue-based reference model.
module tb_fetch_target_queue;
    import fetch_target_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_pred_vld;
    logic            o_ftq_rdy;
    BPInfo_t         i_pred_ftqInfo;
    logic            o_fetch_vld;
    logic            i_fetch_rdy;
    ftqIdx_t         o_fetch_ftqIdx;
    BPInfo_t         o_fetch_info;
    logic            i_squash_vld;
    ftqIdx_t         i_squash_ftqIdx;
    logic            i_commit_vld;
    logic            i_commit_taken;
    logic [XLEN-1:0] i_commit_targetAddr;
    BranchType       i_commit_branch_type;
    logic            o_commit_rdy;
    logic            o_bpu_commit_vld;
    logic            i_bpu_update_finished;
    BPupdateInfo_t   o_BPupdateInfo;

    fetch_target_queue dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_pred_vld            (i_pred_vld),
        .o_ftq_rdy             (o_ftq_rdy),
        .i_pred_ftqInfo        (i_pred_ftqInfo),
        .o_fetch_vld           (o_fetch_vld),
        .i_fetch_rdy           (i_fetch_rdy),
        .o_fetch_ftqIdx        (o_fetch_ftqIdx),
        .o_fetch_info          (o_fetch_info),
        .i_squash_vld          (i_squash_vld),
        .i_squash_ftqIdx       (i_squash_ftqIdx),
        .i_commit_vld          (i_commit_vld),
        .i_commit_taken        (i_commit_taken),
        .i_commit_targetAddr   (i_commit_targetAddr),
        .i_commit_branch_type  (i_commit_branch_type),
        .o_commit_rdy          (o_commit_rdy),
        .o_bpu_commit_vld      (o_bpu_commit_vld),
        .i_bpu_update_finished (i_bpu_update_finished),
        .o_BPupdateInfo        (o_BPupdateInfo)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic BPInfo_t make_info(input logic [XLEN-1:0] start);
        BPInfo_t b;
        b.startAddr   = start;
        b.endAddr     = start + 32'hc;
        b.nextAddr    = start + 32'h10;
        b.taken       = 1'b0;
        b.targetAddr  = '0;
        b.branch_type = BR_NONE;
        return b;
    endfunction

    task automatic idle_inputs();
        i_pred_vld            = 1'b0;
        i_pred_ftqInfo        = '0;
        i_fetch_rdy           = 1'b0;
        i_squash_vld          = 1'b0;
        i_squash_ftqIdx       = '0;
        i_commit_vld          = 1'b0;
        i_commit_taken        = 1'b0;
        i_commit_targetAddr   = '0;
        i_commit_branch_type  = BR_NONE;
        i_bpu_update_finished = 1'b0;
    endtask

    // Inputs are driven at posedge+1; outputs are sampled at posedge+2.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic            pred_vld;
        logic [XLEN-1:0] start;
        logic            fetch_rdy;
        logic            exp_rdy;
        logic            exp_fvld;
        logic [XLEN-1:0] exp_fstart;
        ftqIdx_t         exp_fidx;
    } vec_t;

    vec_t tbl[12];

    // Reference model: the queue contents oldest-first, how many of them are issued, and how
    // many blocks have ever been popped (which fixes each entry's slot index).
    BPInfo_t         mq[$];
    int              m_fetched;
    int              m_popped;
    logic [XLEN-1:0] m_next_start;

    task automatic model_cycle(input bit pv, input bit fr, input bit sv, input int sk,
                               input bit cv, input bit fin, input bit tk);
        BPInfo_t         info;
        logic [XLEN-1:0] tgt;
        bit              e_rdy, e_fv, e_cr, e_bcv;
        info = make_info(m_next_start);
        tgt  = $urandom;
        i_pred_vld            = pv;
        i_pred_ftqInfo        = info;
        i_fetch_rdy           = fr;
        i_squash_vld          = sv;
        i_squash_ftqIdx       = ftqIdx_t'((m_popped + sk) % FTQ_DEPTH);
        i_commit_vld          = cv;
        i_commit_taken        = tk;
        i_commit_targetAddr   = tgt;
        i_commit_branch_type  = BR_COND;
        i_bpu_update_finished = fin;
        #1;
        e_rdy = (mq.size() < FTQ_DEPTH) && !sv;
        e_fv  = (m_fetched < mq.size()) && !sv;
        e_cr  = m_fetched > 0;
        e_bcv = cv && e_cr;
        check("m_ftq_rdy", 64'(o_ftq_rdy), 64'(e_rdy));
        check("m_fetch_vld", 64'(o_fetch_vld), 64'(e_fv));
        check("m_commit_rdy", 64'(o_commit_rdy), 64'(e_cr));
        check("m_bpu_commit_vld", 64'(o_bpu_commit_vld), 64'(e_bcv));
        if (e_fv) begin
            check("m_fetch_idx", 64'(o_fetch_ftqIdx), 64'((m_popped + m_fetched) % FTQ_DEPTH));
            check("m_fetch_start", 64'(o_fetch_info.startAddr), 64'(mq[m_fetched].startAddr));
        end
        if (e_cr) begin
            check("m_upd_start", 64'(o_BPupdateInfo.startAddr), 64'(mq[0].startAddr));
            check("m_upd_fallthru", 64'(o_BPupdateInfo.fallthruAddr), 64'(mq[0].endAddr));
            check("m_upd_target", 64'(o_BPupdateInfo.targetAddr), 64'(tgt));
            check("m_upd_taken", 64'(o_BPupdateInfo.taken), 64'(tk));
        end
        @(posedge clk);
        if (sv) begin
            while (mq.size() > sk + 1) void'(mq.pop_back());
            m_fetched = sk + 1;
        end
        if (e_bcv && fin) begin
            void'(mq.pop_front());
            m_fetched--;
            m_popped++;
        end
        if (e_fv && fr) m_fetched++;
        if (e_rdy && pv) begin
            mq.push_back(info);
            m_next_start = m_next_start + 32'h10;
        end
        #1;
    endtask

    initial begin
        int pops;

        tbl[0]  = '{1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 32'h0,    ftqIdx_t'(0)};
        tbl[1]  = '{1'b1, 32'h1010, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[2]  = '{1'b1, 32'h1020, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[3]  = '{1'b1, 32'h1030, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[4]  = '{1'b1, 32'h1040, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[5]  = '{1'b1, 32'h1050, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[6]  = '{1'b1, 32'h1060, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[7]  = '{1'b1, 32'h1070, 1'b0, 1'b1, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[8]  = '{1'b1, 32'h1080, 1'b0, 1'b0, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[9]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h1000, ftqIdx_t'(0)};
        tbl[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h1010, ftqIdx_t'(1)};
        tbl[11] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h1020, ftqIdx_t'(2)};

        idle_inputs();
        rst = 1'b1;
        next_cycle();
        check("rst_ftq_rdy", 64'(o_ftq_rdy), 64'(0));
        check("rst_fetch_vld", 64'(o_fetch_vld), 64'(0));
        check("rst_commit_rdy", 64'(o_commit_rdy), 64'(0));
        next_cycle();
        rst = 1'b0;
        #1;
        check("post_rst_fetch_vld", 64'(o_fetch_vld), 64'(0));
        check("post_rst_commit_rdy", 64'(o_commit_rdy), 64'(0));
        check("post_rst_bpu_vld", 64'(o_bpu_commit_vld), 64'(0));
        check("post_rst_fetch_info", 64'(o_fetch_info.startAddr), 64'(0));
        check("post_rst_upd", 64'(o_BPupdateInfo.startAddr), 64'(0));

        // Fill to full with fetch stalled, then issue three blocks.
        for (int i = 0; i < 12; i++) begin
            i_pred_vld     = tbl[i].pred_vld;
            i_pred_ftqInfo = make_info(tbl[i].start);
            i_fetch_rdy    = tbl[i].fetch_rdy;
            #1;
            check($sformatf("tbl%0d_ftq_rdy", i), 64'(o_ftq_rdy), 64'(tbl[i].exp_rdy));
            check($sformatf("tbl%0d_fetch_vld", i), 64'(o_fetch_vld), 64'(tbl[i].exp_fvld));
            if (tbl[i].exp_fvld) begin
                check($sformatf("tbl%0d_fetch_start", i), 64'(o_fetch_info.startAddr), 64'(tbl[i].exp_fstart));
                check($sformatf("tbl%0d_fetch_idx", i), 64'(o_fetch_ftqIdx), 64'(tbl[i].exp_fidx));
            end
            next_cycle();
        end

        // Squash at idx 1 while the BPU offers another block.
        i_pred_vld      = 1'b1;
        i_pred_ftqInfo  = make_info(32'h1080);
        i_fetch_rdy     = 1'b1;
        i_squash_vld    = 1'b1;
        i_squash_ftqIdx = ftqIdx_t'(1);
        #1;
        check("sq_ftq_rdy", 64'(o_ftq_rdy), 64'(0));
        check("sq_fetch_vld", 64'(o_fetch_vld), 64'(0));
        next_cycle();
        i_squash_vld   = 1'b0;
        i_pred_ftqInfo = make_info(32'h2100);
        #1;
        check("sq_next_fetch_vld", 64'(o_fetch_vld), 64'(0));
        check("sq_next_ftq_rdy", 64'(o_ftq_rdy), 64'(1));
        next_cycle();
        i_pred_vld = 1'b0;
        #1;
        check("sq_refetch_vld", 64'(o_fetch_vld), 64'(1));
        check("sq_refetch_idx", 64'(o_fetch_ftqIdx), 64'(2));
        check("sq_refetch_start", 64'(o_fetch_info.startAddr), 64'(32'h2100));
        next_cycle();

        // Commit the head while the BPU update takes three cycles.
        i_fetch_rdy          = 1'b0;
        i_commit_vld         = 1'b1;
        i_commit_taken       = 1'b1;
        i_commit_targetAddr  = 32'h2000;
        i_commit_branch_type = BR_JUMP;
        for (int c = 0; c < 3; c++) begin
            i_bpu_update_finished = (c == 2);
            #1;
            check($sformatf("cm%0d_bpu_vld", c), 64'(o_bpu_commit_vld), 64'(1));
            check($sformatf("cm%0d_start", c), 64'(o_BPupdateInfo.startAddr), 64'(32'h1000));
            check($sformatf("cm%0d_fallthru", c), 64'(o_BPupdateInfo.fallthruAddr), 64'(32'h100c));
            check($sformatf("cm%0d_target", c), 64'(o_BPupdateInfo.targetAddr), 64'(32'h2000));
            check($sformatf("cm%0d_taken", c), 64'(o_BPupdateInfo.taken), 64'(1));
            check($sformatf("cm%0d_type", c), 64'(o_BPupdateInfo.branch_type), 64'(BR_JUMP));
            next_cycle();
        end
        i_commit_vld          = 1'b0;
        i_bpu_update_finished = 1'b0;
        #1;
        check("cm_new_head", 64'(o_BPupdateInfo.startAddr), 64'(32'h1010));
        check("cm_commit_rdy", 64'(o_commit_rdy), 64'(1));
        next_cycle();

        // Squash the head in the same cycle it commits: the queue empties.
        i_squash_vld          = 1'b1;
        i_squash_ftqIdx       = ftqIdx_t'(1);
        i_commit_vld          = 1'b1;
        i_bpu_update_finished = 1'b1;
        #1;
        check("sqcm_bpu_vld", 64'(o_bpu_commit_vld), 64'(1));
        next_cycle();
        idle_inputs();
        #1;
        check("sqcm_fetch_vld", 64'(o_fetch_vld), 64'(0));
        check("sqcm_commit_rdy", 64'(o_commit_rdy), 64'(0));
        check("sqcm_ftq_rdy", 64'(o_ftq_rdy), 64'(1));
        next_cycle();

        // Five blocks pending, then reset.
        i_fetch_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_pred_vld     = 1'b1;
            i_pred_ftqInfo = make_info(32'h3000 + 32'(i * 16));
            next_cycle();
        end
        rst = 1'b1;
        #1;
        check("rst2_ftq_rdy", 64'(o_ftq_rdy), 64'(0));
        check("rst2_fetch_vld", 64'(o_fetch_vld), 64'(0));
        check("rst2_commit_rdy", 64'(o_commit_rdy), 64'(0));
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst2_after_fetch_vld", 64'(o_fetch_vld), 64'(0));
        check("rst2_after_commit_rdy", 64'(o_commit_rdy), 64'(0));
        check("rst2_after_fetch_info", 64'(o_fetch_info.startAddr), 64'(0));
        check("rst2_after_ftq_rdy", 64'(o_ftq_rdy), 64'(1));

        // Model-checked traffic from the fresh reset state.
        mq.delete();
        m_fetched    = 0;
        m_popped     = 0;
        m_next_start = 32'h4000;
        model_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        i_pred_vld = 1'b0;
        #1;
        check("first_enq_idx", 64'(o_fetch_ftqIdx), 64'(0));
        check("first_enq_start", 64'(o_fetch_info.startAddr), 64'(32'h4000));

        for (int c = 0; c < 40 && m_popped < 20; c++)
            model_cycle(1'b1, 1'b1, 1'b0, 0, m_fetched > 0, 1'b1, c[0]);
        check("continuous_pops", 64'(m_popped), 64'(20));
        pops = m_popped;

        for (int c = 0; c < 400; c++) begin
            bit sv, cv;
            int sk;
            sv = (m_fetched > 0) && ($urandom_range(0, 15) == 0);
            sk = sv ? int'($urandom_range(0, m_fetched - 1)) : 0;
            cv = (m_fetched > 0) && ($urandom_range(0, 1) == 1);
            model_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, sv, sk,
                        cv, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        check("random_progress", 64'(m_popped > pops + 20), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
